matmul_sequencer: RTL and testbench

Central controller for the UART matrix-multiply datapath.
- Takes the byte stream from uart_rx and writes the first N*N bytes into matrix A memory and the next N*N bytes into matrix B memory.
- Then pulses the multiplier start, waits for its done, reads the N*N results and streams them to uart_tx.
- Sits between the UART pair, the two matrix_memory instances, the multiplier and its result buffer; replaces ad-hoc enable wiring with explicit address generation and handshakes.

---
 rtl/matmul_pkg.sv | 36 +++
 rtl/matmul_tx_serializer.sv | 93 +++++++++
 rtl/matmul_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and default sizing for the UART matrix-multiply
// sequencer and its transmit serializer.
//   - seq_state_e : top-level sequencer states
//   - ser_state_e : serializer states
//   - N_DEF / DW_DEF / RW_DEF : default matrix dimension and element widths
//   - AW_DEF, BYTES_PER_RES   : derived address width and bytes per result word
package matmul_pkg;

   localparam int unsigned N_DEF         = 2;
   localparam int unsigned DW_DEF        = 8;
   localparam int unsigned RW_DEF        = 16;
   localparam int unsigned AW_DEF        = $clog2(N_DEF * N_DEF);
   localparam int unsigned BYTES_PER_RES = RW_DEF / 8;

   // TX_BYTE/TX_WAIT are folded into StSend; the serializer owns the byte loop.
   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StStart,
      StWaitMul,
      StRdRes,
      StSend
   } seq_state_e;

   typedef enum logic [1:0] {
      SerIdle,
      SerByte,
      SerWait
   } ser_state_e;

   function automatic int unsigned bytes_per_word(input int unsigned rw);
      return rw / 8;
   endfunction

endpackage

// File: rtl/matmul_tx_serializer.sv
// matmul_tx_serializer: takes one RW-bit result word and sends it to uart_tx
// as RW/8 bytes, most significant byte first.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : one-cycle strobe, latch word and start sending
//   word          : result word to send
//   tx_busy       : uart_tx busy
//   tx_start      : one-cycle transmit request (registered)
//   tx_data       : byte to transmit (registered)
//   done          : one-cycle pulse after the last byte has been accepted
//   waiting       : high while waiting for uart_tx to finish a byte
module matmul_tx_serializer
   import matmul_pkg::*;
#(
   parameter int unsigned RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [RW-1:0] word,
   input  logic          tx_busy,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   output logic          done,
   output logic          waiting
);

   localparam int unsigned Bytes = bytes_per_word(RW);
   localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

   ser_state_e      state_q;
   logic [RW-1:0]   shreg_q;
   logic [CntW-1:0] cnt_q;
   logic            first_q;
   logic            tx_start_q;
   logic [7:0]      tx_data_q;
   logic            done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SerIdle;
         shreg_q    <= '0;
         cnt_q      <= '0;
         first_q    <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         unique case (state_q)
            SerIdle: begin
               if (load) begin
                  shreg_q <= word;
                  cnt_q   <= CntW'(Bytes - 1);
                  state_q <= SerByte;
               end
            end
            SerByte: begin
               if (!tx_busy) begin
                  tx_start_q <= 1'b1;
                  tx_data_q  <= shreg_q[RW-1 -: 8];
                  shreg_q    <= shreg_q << 8;
                  first_q    <= 1'b1;
                  state_q    <= SerWait;
               end
            end
            SerWait: begin
               // uart_tx only raises busy after it has seen tx_start, so the
               // first cycle here says nothing about the new byte.
               if (first_q) begin
                  first_q <= 1'b0;
               end else if (!tx_busy) begin
                  if (cnt_q == '0) begin
                     done_q  <= 1'b1;
                     state_q <= SerIdle;
                  end else begin
                     cnt_q   <= cnt_q - 1'b1;
                     state_q <= SerByte;
                  end
               end
            end
            default: state_q <= SerIdle;
         endcase
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign done     = done_q;
   assign waiting  = (state_q == SerWait);

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: central controller for the UART matrix-multiply datapath.
// Loads N*N bytes into matrix A memory and the next N*N into matrix B memory,
// pulses the multiplier, then streams the N*N results MSB-byte first to uart_tx.
// Optional watchdog: define MATMUL_SEQ_TIMEOUT_EN to abort to IDLE with an err
// pulse when mult_done or the end of tx_busy is not seen within TIMEOUT_CYC.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   tx_busy               : uart_tx busy
//   tx_start, tx_data     : one-cycle transmit request and byte
//   mem_wdata             : write data shared by A and B memories
//   a_we, a_addr          : A memory write enable and address
//   b_we, b_addr          : B memory write enable and address
//   mult_start, mult_done : multiplier start pulse and completion strobe
//   res_addr, res_data    : result buffer read address, data one cycle later
//   busy                  : high in every state except IDLE
//   err                   : one-cycle watchdog error pulse
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter int unsigned N           = N_DEF,
   parameter int unsigned DW          = DW_DEF,
   parameter int unsigned RW          = RW_DEF,
   parameter int unsigned AW          = $clog2(N * N),
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          tx_busy,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   output logic [DW-1:0] mem_wdata,
   output logic          a_we,
   output logic [AW-1:0] a_addr,
   output logic          b_we,
   output logic [AW-1:0] b_addr,
   output logic          mult_start,
   input  logic          mult_done,
   output logic [AW-1:0] res_addr,
   input  logic [RW-1:0] res_data,
   output logic          busy,
   output logic          err
);

   localparam logic [AW-1:0] LastIdx = AW'(N * N - 1);

   seq_state_e    state_q;
   logic [AW-1:0] idx_q;
   logic [AW-1:0] r_q;
   logic [AW-1:0] a_addr_q;
   logic [AW-1:0] b_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic          a_we_q;
   logic          b_we_q;
   logic          mult_start_q;
   logic          ser_load_q;
   logic          ser_rst;
   logic          ser_done;
   logic          ser_wait;
   logic          wd_fire;

`ifdef MATMUL_SEQ_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

   logic [WdW-1:0] wd_cnt_q;
   logic           err_q;
   logic           wd_run;

   // Count only while the awaited event is still missing.
   assign wd_run  = ((state_q == StWaitMul) && !mult_done) ||
                    ((state_q == StSend) && ser_wait && tx_busy);
   assign wd_fire = wd_run && (wd_cnt_q == WdW'(TIMEOUT_CYC - 1));
   assign err     = err_q;
`else
   logic unused_wd;

   assign wd_fire   = 1'b0;
   assign err       = 1'b0;
   assign unused_wd = ^{TIMEOUT_CYC, ser_wait};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         r_q          <= '0;
         a_addr_q     <= '0;
         b_addr_q     <= '0;
         mem_wdata_q  <= '0;
         a_we_q       <= 1'b0;
         b_we_q       <= 1'b0;
         mult_start_q <= 1'b0;
         ser_load_q   <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
         wd_cnt_q     <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         a_we_q       <= 1'b0;
         b_we_q       <= 1'b0;
         mult_start_q <= 1'b0;
         ser_load_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // The byte that wakes us up is A[0].
               if (rx_valid) begin
                  a_we_q      <= 1'b1;
                  a_addr_q    <= '0;
                  mem_wdata_q <= DW'(rx_data);
                  idx_q       <= AW'(1);
                  state_q     <= StLoadA;
               end
            end
            StLoadA: begin
               if (rx_valid) begin
                  a_we_q      <= 1'b1;
                  a_addr_q    <= idx_q;
                  mem_wdata_q <= DW'(rx_data);
                  if (idx_q == LastIdx) begin
                     idx_q   <= '0;
                     state_q <= StLoadB;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            StLoadB: begin
               if (rx_valid) begin
                  b_we_q      <= 1'b1;
                  b_addr_q    <= idx_q;
                  mem_wdata_q <= DW'(rx_data);
                  if (idx_q == LastIdx) begin
                     idx_q   <= '0;
                     state_q <= StStart;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            StStart: begin
               mult_start_q <= 1'b1;
               state_q      <= StWaitMul;
            end
            StWaitMul: begin
               if (mult_done) begin
                  r_q     <= '0;
                  state_q <= StRdRes;
               end
            end
            StRdRes: begin
               // res_addr already shows r; the serializer latches res_data
               // on the following cycle when it is valid.
               ser_load_q <= 1'b1;
               state_q    <= StSend;
            end
            StSend: begin
               if (ser_done) begin
                  if (r_q == LastIdx) begin
                     r_q     <= '0;
                     state_q <= StIdle;
                  end else begin
                     r_q     <= r_q + 1'b1;
                     state_q <= StRdRes;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase

`ifdef MATMUL_SEQ_TIMEOUT_EN
         err_q <= 1'b0;
         if (!wd_run) begin
            wd_cnt_q <= '0;
         end else if (wd_fire) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b1;
            state_q  <= StIdle;
            idx_q    <= '0;
            r_q      <= '0;
         end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
         end
`endif
      end
   end

   // A watchdog abort also clears any half-sent word.
   assign ser_rst = rst | wd_fire;

   matmul_tx_serializer #(
      .RW (RW)
   ) u_ser (
      .clk      (clk),
      .rst      (ser_rst),
      .load     (ser_load_q),
      .word     (res_data),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .done     (ser_done),
      .waiting  (ser_wait)
   );

   assign mem_wdata  = mem_wdata_q;
   assign a_we       = a_we_q;
   assign a_addr     = a_addr_q;
   assign b_we       = b_we_q;
   assign b_addr     = b_addr_q;
   assign mult_start = mult_start_q;
   assign res_addr   = r_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer (N=2, 16-bit results).
module tb_matmul_sequencer;

   localparam int unsigned N  = 2;
   localparam int unsigned NN = N * N;
   localparam int unsigned RW = 16;
   localparam int unsigned AW = 2;
`ifdef MATMUL_SEQ_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 1000;
`else
   localparam int unsigned TB_TIMEOUT = 4096;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          tx_busy = 1'b0;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic [7:0]    mem_wdata;
   logic          a_we, b_we;
   logic [AW-1:0] a_addr, b_addr, res_addr;
   logic          mult_start;
   logic          mult_done;
   logic          mult_done_mdl = 1'b0;
   logic          stray_done = 1'b0;
   logic [RW-1:0] res_data = '0;
   logic          busy, err;

   assign mult_done = mult_done_mdl | stray_done;

   matmul_sequencer #(
      .N           (N),
      .DW          (8),
      .RW          (RW),
      .AW          (AW),
      .TIMEOUT_CYC (TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .mem_wdata  (mem_wdata),
      .a_we       (a_we),
      .a_addr     (a_addr),
      .b_we       (b_we),
      .b_addr     (b_addr),
      .mult_start (mult_start),
      .mult_done  (mult_done),
      .res_addr   (res_addr),
      .res_data   (res_data),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int busy_len = 3;
   int mul_delay = 5;
   int mul_left = 0;
   bit mul_hold = 1'b0;
   int busy_left = 0;
   int overlap = 0;
   int busy_fall = -1;
   logic busy_prev = 1'b0;

   logic [7:0]    mem_a [NN];
   logic [7:0]    mem_b [NN];
   logic [RW-1:0] c_mem [NN];
   logic [7:0]    stim [2*NN];

   int            rx_cyc [$];
   int            a_cyc [$];
   int            b_cyc [$];
   int            ms_cyc [$];
   int            tx_cyc [$];
   int            err_cyc [$];
   logic [AW-1:0] a_adr [$];
   logic [AW-1:0] b_adr [$];
   logic [7:0]    a_dat [$];
   logic [7:0]    b_dat [$];
   logic [7:0]    tx_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx model: busy for busy_len cycles starting the cycle after tx_start.
   always @(posedge clk) begin
      if (tx_start) begin
         tx_busy   <= 1'b1;
         busy_left <= busy_len;
      end else if (busy_left > 1) begin
         busy_left <= busy_left - 1;
      end else begin
         busy_left <= 0;
         tx_busy   <= 1'b0;
      end
   end

   // Result buffer: registered read.
   always @(posedge clk) res_data <= c_mem[res_addr];

   // Monitor, A/B memories and multiplier model.
   always @(negedge clk) begin
      if (a_we) begin
         a_cyc.push_back(cyc);
         a_adr.push_back(a_addr);
         a_dat.push_back(mem_wdata);
         mem_a[a_addr] = mem_wdata;
      end
      if (b_we) begin
         b_cyc.push_back(cyc);
         b_adr.push_back(b_addr);
         b_dat.push_back(mem_wdata);
         mem_b[b_addr] = mem_wdata;
      end
      if (tx_start) begin
         tx_q.push_back(tx_data);
         tx_cyc.push_back(cyc);
         if (tx_busy) overlap++;
      end
      if (err) err_cyc.push_back(cyc);
      if (busy_prev && !busy) busy_fall = cyc;
      busy_prev = busy;
      mult_done_mdl = 1'b0;
      if (mul_left == 1) mult_done_mdl = 1'b1;
      if (mul_left > 0) mul_left--;
      if (mult_start) begin
         ms_cyc.push_back(cyc);
         if (!mul_hold) begin
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  int acc;
                  acc = 0;
                  for (int k = 0; k < N; k++)
                     acc += int'(mem_a[i*N+k]) * int'(mem_b[k*N+j]);
                  c_mem[i*N+j] = acc[RW-1:0];
               end
            end
            mul_left = mul_delay;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic randomize_stim();
      for (int i = 0; i < 2*NN; i++) stim[i] = 8'($urandom_range(255, 0));
   endtask

   // Sends stim[0..count-1]; gap 0 keeps rx_valid high back-to-back.
   task automatic send_stim(input int gap_max, input int count);
      for (int i = 0; i < count; i++) begin
         int g;
         @(posedge clk); #1;
         rx_valid = 1'b1;
         rx_data  = stim[i];
         rx_cyc.push_back(cyc);
         g = $urandom_range(gap_max, 0);
         for (int k = 0; k < g; k++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      ok = !busy;
      @(negedge clk);
   endtask

   task automatic run_txn(input string name, input int gap_max, input int blen, input bit stray);
      int a0, b0, m0, t0, e0, r0, n;
      bit ok;
      logic [7:0] exp_q [$];
      busy_len = blen;
      a0 = a_cyc.size(); b0 = b_cyc.size(); m0 = ms_cyc.size();
      t0 = tx_q.size(); e0 = err_cyc.size(); r0 = rx_cyc.size();
      send_stim(gap_max, 2*NN);
      if (stray) begin
         n = 0;
         while (tx_q.size() == t0 && n < 20000) begin
            @(negedge clk);
            n++;
         end
         check_eq({name, "_tx_started"}, 64'(tx_q.size() > t0), 1);
         @(posedge clk); #1;
         rx_valid = 1'b1;
         rx_data  = 8'hFF;
         @(posedge clk); #1;
         rx_valid = 1'b0;
      end
      wait_idle(30000, ok);
      check_eq({name, "_finished"}, 64'(ok), 1);

      // Reference: C = A x B, row-major, each result sent high byte first.
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < N; k++) acc += int'(stim[i*N+k]) * int'(stim[NN+k*N+j]);
            exp_q.push_back(acc[15:8]);
            exp_q.push_back(acc[7:0]);
         end
      end

      check_eq({name, "_a_we_count"}, 64'(a_cyc.size() - a0), NN);
      check_eq({name, "_b_we_count"}, 64'(b_cyc.size() - b0), NN);
      for (int i = 0; i < NN && a0 + i < a_cyc.size(); i++) begin
         check_eq($sformatf("%s_a_addr%0d", name, i), 64'(a_adr[a0+i]), 64'(i));
         check_eq($sformatf("%s_a_data%0d", name, i), 64'(a_dat[a0+i]), 64'(stim[i]));
         check_eq($sformatf("%s_a_lat%0d", name, i), 64'(a_cyc[a0+i] - rx_cyc[r0+i]), 1);
      end
      for (int i = 0; i < NN && b0 + i < b_cyc.size(); i++) begin
         check_eq($sformatf("%s_b_addr%0d", name, i), 64'(b_adr[b0+i]), 64'(i));
         check_eq($sformatf("%s_b_data%0d", name, i), 64'(b_dat[b0+i]), 64'(stim[NN+i]));
         check_eq($sformatf("%s_b_lat%0d", name, i), 64'(b_cyc[b0+i] - rx_cyc[r0+NN+i]), 1);
      end
      check_eq({name, "_mult_start_count"}, 64'(ms_cyc.size() - m0), 1);
      if (ms_cyc.size() > m0)
         check_eq({name, "_mult_start_lat"}, 64'(ms_cyc[m0] - rx_cyc[r0+2*NN-1]), 2);
      check_eq({name, "_tx_count"}, 64'(tx_q.size() - t0), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && t0 + i < tx_q.size(); i++)
         check_eq($sformatf("%s_tx_byte%0d", name, i), 64'(tx_q[t0+i]), 64'(exp_q[i]));
      if (tx_cyc.size() > 0)
         check_eq({name, "_busy_after_last_byte"}, 64'(busy_fall > tx_cyc[$]), 1);
      check_eq({name, "_no_err"}, 64'(err_cyc.size() - e0), 0);
   endtask

   initial begin
      int m0, t0, e0, n;
      bit ok;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_busy", 64'(busy), 0);
      check_eq("reset_err", 64'(err), 0);
      check_eq("reset_strobes", 64'({tx_start, a_we, b_we, mult_start}), 0);
      check_eq("reset_data", 64'({tx_data, mem_wdata}), 0);
      check_eq("reset_addrs", 64'({a_addr, b_addr, res_addr}), 0);
      #1 rst = 1'b0;

      // Nominal run: A = 1 2 3 4, B = 5 6 7 8.
      for (int i = 0; i < 2*NN; i++) stim[i] = 8'(i + 1);
      run_txn("nominal", 3, 3, 1'b0);

      // Burst: eight back-to-back rx_valid.
      randomize_stim();
      run_txn("burst", 0, 2, 1'b0);

      // Heavy tx backpressure.
      randomize_stim();
      run_txn("backpressure", 1, 500, 1'b0);
      check_eq("no_start_while_busy", 64'(overlap), 0);

      // Stray rx byte during transmit.
      randomize_stim();
      run_txn("stray_rx", 2, 20, 1'b1);

      // Stray mult_done while idle.
      m0 = ms_cyc.size();
      t0 = tx_q.size();
      @(posedge clk); #1 stray_done = 1'b1;
      @(posedge clk); #1 stray_done = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("stray_done_idle", 64'(busy), 0);
      check_eq("stray_done_no_tx", 64'(tx_q.size() - t0), 0);
      check_eq("stray_done_no_start", 64'(ms_cyc.size() - m0), 0);

      // Reset after three A bytes, then a fresh full transaction.
      randomize_stim();
      send_stim(1, 3);
      do_reset();
      @(negedge clk);
      check_eq("midreset_idle", 64'(busy), 0);
      randomize_stim();
      run_txn("after_reset", 2, 4, 1'b0);

      // A few random transactions.
      for (int t = 0; t < 3; t++) begin
         randomize_stim();
         run_txn($sformatf("rand%0d", t), $urandom_range(3, 0), $urandom_range(40, 1), 1'b0);
      end

      // Withheld mult_done.
      mul_hold = 1'b1;
      randomize_stim();
      m0 = ms_cyc.size();
      e0 = err_cyc.size();
      t0 = tx_q.size();
      send_stim(1, 2*NN);
      n = 0;
      while (ms_cyc.size() == m0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("hold_mult_start_seen", 64'(ms_cyc.size() - m0), 1);
`ifdef MATMUL_SEQ_TIMEOUT_EN
      n = 0;
      while (err_cyc.size() == e0 && n < int'(TB_TIMEOUT) + 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("wd_err_seen", 64'(err_cyc.size() - e0), 1);
      if (err_cyc.size() > e0 && ms_cyc.size() > m0)
         check_eq("wd_err_cycle", 64'(err_cyc[e0] - ms_cyc[m0]), 64'(TB_TIMEOUT));
      @(negedge clk);
      check_eq("wd_back_idle", 64'(busy), 0);
`else
      repeat (10000) @(negedge clk);
      check_eq("hold_still_waiting", 64'(busy), 1);
      check_eq("hold_no_err", 64'(err_cyc.size() - e0), 0);
`endif
      check_eq("hold_no_tx", 64'(tx_q.size() - t0), 0);
      mul_hold = 1'b0;
      do_reset();
      randomize_stim();
      run_txn("recover", 1, 5, 1'b0);
      wait_idle(10, ok);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
